// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard scoreboard: PC-source codes and pipeline control modes.
package hazard_pkg;

   localparam logic [2:0] PCSRC_SEQ    = 3'd0;
   localparam logic [2:0] PCSRC_BRANCH = 3'd1;
   localparam logic [2:0] PCSRC_JUMP   = 3'd2;
   localparam logic [2:0] PCSRC_JR     = 3'd3;
   localparam logic [2:0] PCSRC_EXC    = 3'd4;
   localparam logic [2:0] PCSRC_ILLOP  = 3'd5;

   typedef enum logic [2:0] {
      MODE_FREEZE,
      MODE_BRANCH,
      MODE_STALL,
      MODE_JUMP,
      MODE_NORMAL
   } mode_t;

   // Any PC source decoded in ID that discards the instruction already fetched behind it.
   function automatic logic is_id_redirect(input logic [2:0] pcsrc);
      return (pcsrc == PCSRC_JUMP) || (pcsrc == PCSRC_JR) ||
             (pcsrc == PCSRC_EXC)  || (pcsrc == PCSRC_ILLOP);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts enabled cycles, sticks at all-ones, async clear.
// Value visible one cycle after the enabled cycle; no backpressure.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Load-use scoreboard plus freeze/branch/jump arbitration driving PC, IF/ID and ID/EX controls.
// Controls are combinational from the current cycle; scoreboard and stats update on the clock edge.
module hazard_scoreboard_unit
   import hazard_pkg::*;
#(
   parameter  int NREG     = 32,
   parameter  int LOAD_LAT = 1,
   parameter  int STAT_W   = 16,
   localparam int REG_AW   = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              id_is_load,
   input  logic [REG_AW-1:0] id_wr_reg,
   input  logic [2:0]        id_pcsrc,
   input  logic [2:0]        ex_pcsrc,
   input  logic              ex_alu_result0,
   input  logic              mem_busy,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic [STAT_W-1:0] stall_cnt,
   output logic [STAT_W-1:0] flush_cnt
);

   localparam int CW = $clog2(LOAD_LAT + 1);

   logic [CW-1:0] cnt [NREG];
   logic          rs_pend;
   logic          rt_pend;
   logic          hazard;
   logic          br_taken;
   logic          advance;
   logic          issue_load;
   mode_t         mode;

   assign rs_pend  = id_uses_rs && (id_rs != '0) && (cnt[id_rs] != '0);
   assign rt_pend  = id_uses_rt && (id_rt != '0) && (cnt[id_rt] != '0);
   assign hazard   = id_valid && (rs_pend || rt_pend);
   assign br_taken = (ex_pcsrc == PCSRC_BRANCH) && ex_alu_result0;

   // Reset forces NORMAL so a freeze or stall in progress releases the pipeline at once.
   always_comb begin
      mode = MODE_NORMAL;
      if (reset)                        mode = MODE_NORMAL;
      else if (mem_busy)                mode = MODE_FREEZE;
      else if (br_taken)                mode = MODE_BRANCH;
      else if (hazard)                  mode = MODE_STALL;
      else if (is_id_redirect(id_pcsrc)) mode = MODE_JUMP;
   end

   always_comb begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      case (mode)
         MODE_FREEZE: begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
         end
         MODE_BRANCH: begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end
         MODE_STALL: begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
         end
         MODE_JUMP:   if_id_flush = 1'b1;
         default:     ;
      endcase
   end

   assign advance    = (mode != MODE_FREEZE);
   assign issue_load = ((mode == MODE_JUMP) || (mode == MODE_NORMAL)) &&
                       id_valid && id_is_load && (id_wr_reg != '0);

   // Entry 0 is cleared by reset and never written afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) cnt[i] <= '0;
      end else if (advance) begin
         for (int i = 1; i < NREG; i++) begin
            if (issue_load && (id_wr_reg == REG_AW'(i))) begin
               cnt[i] <= CW'(LOAD_LAT);
            end else if (cnt[i] != '0) begin
               cnt[i] <= cnt[i] - 1'b1;
            end
         end
      end
   end

   sat_counter #(.W(STAT_W)) u_stall_stat (
      .clk   (clk),
      .reset (reset),
      .en    (mode == MODE_STALL),
      .count (stall_cnt)
   );

   sat_counter #(.W(STAT_W)) u_flush_stat (
      .clk   (clk),
      .reset (reset),
      .en    ((mode == MODE_BRANCH) || (mode == MODE_JUMP)),
      .count (flush_cnt)
   );

endmodule
